instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Fetch-stage producer that drives the fetch-to-decode pipeline register.
- Owns the program counter and issues one instruction-memory request at a time over a valid/ready request channel, then accepts the response.
- Presents {pcOut, instOut, validOut} to the F/D register and holds them while the hazard unit stalls.
- Handles branch/jump redirects, including discarding responses that are stale when a redirect arrives.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- PC_STEP, 4, PC increment per sequential fetch

Ports:
- clock  in  1  single clock, all state updates on posedge
- reset  in  1  synchronous, active-low; reset==1'b0 at posedge clears state
- imemReqValid  out  1  request valid
- imemReqReady  in  1  memory accepts request
- imemReqAddr  out  32  fetch address, word aligned
- imemRespValid  in  1  response data valid (one per accepted request, latency >=1)
- imemRespData  in  32  instruction word
- redirectValid  in  1  taken branch/jump from execute
- redirectPc  in  32  redirect target; bits[1:0] forced to 0
- stall  in  1  decode cannot accept; F/D register holds
- pcOut  out  32  PC of presented instruction
- instOut  out  32  presented instruction
- validOut  out  1  pcOut/instOut hold a live instruction

Behaviour:
- Reset (reset==0 at posedge):
  - fetchPc<=RESET_PC, state<=S_REQ, discard<=0.
  - pcOut<=0, instOut<=0, validOut<=0, hold buffer cleared.
  - imemReqValid is 0 during the reset cycle.
- Outputs:
  - imemReqValid = (state==S_REQ) && reset. Combinational from state only, never from imemReqReady.
  - imemReqAddr = fetchPc.
  - pcOut/instOut/validOut are registered.
- Output slot rules:
  - The slot is free when validOut==0 or stall==0.
  - Consumption: validOut&&!stall at a posedge means the F/D register took the instruction. If nothing new loads that cycle, validOut<=0.
- S_REQ:
  - On imemReqValid&&imemReqReady: reqPc<=fetchPc, fetchPc<=fetchPc+PC_STEP (mod 2^32, so 32'hFFFF_FFFC wraps to 0), go S_WAIT.
  - Otherwise stay, with address stable.
- S_WAIT, on imemRespValid:
  - discard==1: drop the data, discard<=0, go S_REQ.
  - Slot free: pcOut<=reqPc, instOut<=imemRespData, validOut<=1, go S_REQ.
  - Slot not free: holdPc<=reqPc, holdInst<=imemRespData, go S_HOLD.
- S_HOLD:
  - No new request is issued.
  - When stall==0: pcOut<=holdPc, instOut<=holdInst, validOut<=1, go S_REQ.
- Latency: best case, request accepted at cycle N and response at N+1 gives validOut=1 at N+2. Throughput is 1 instruction per 2 cycles (single outstanding request, by design).
- Redirect (highest priority, overrides stall):
  - fetchPc<=redirectPc&~3, validOut<=0, and the hold buffer is dropped.
  - From S_REQ with no handshake, or from S_HOLD: go S_REQ.
  - From S_REQ with a simultaneous handshake: go S_WAIT, discard<=1.
  - From S_WAIT with no response this cycle: stay in S_WAIT, discard<=1.
  - From S_WAIT with a response this cycle: drop the response, go S_REQ.
- imemRespValid outside S_WAIT is ignored. This also covers responses still in flight across a mid-operation reset.
- pcOut/instOut hold their values whenever validOut is 0 or stall is 1.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {S_REQ, S_WAIT, S_HOLD}
  - PC_WIDTH=32, INST_WIDTH=32
  - RESET_PC default
- One sub-module, fetch_hold_buffer: single-entry pc/inst holding register with load/clear/valid, same clock/reset convention.

Test Plan:
- Reset then free-run (ready=1, response at 1-cycle latency, stall=0) -> imemReqAddr sequence 0,4,8,C; validOut pulses with pcOut 0,4,8 and the matching instOut; reset low mid-run -> next cycle validOut=0, imemReqAddr=0.
- Response arrives while stall=1 and validOut=1 -> state S_HOLD, no new request, pcOut unchanged; stall drops -> pcOut=held PC next cycle, then request to the next PC.
- Redirect to 32'h0000_0100 while in S_WAIT -> the late response (inst 32'hDEADBEEF) never appears on instOut; the next request address is 0x100 and pcOut later =0x100.
- Redirect in the same cycle as a response, and redirect with redirectPc=32'h0000_0103 -> response dropped, validOut=0, next imemReqAddr=32'h0000_0100.
- imemReqReady held low 5 cycles -> imemReqValid stays 1 with a constant address; fetchPc=32'hFFFF_FFFC -> after acceptance the next address is 0.
- Stall asserted with a redirect -> validOut cleared despite the stall (flush wins).

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
  localparam int PC_WIDTH   = 32;
  localparam int INST_WIDTH = 32;
  localparam logic [PC_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_t;

  function automatic logic [PC_WIDTH-1:0] align_word(input logic [PC_WIDTH-1:0] pc);
    return {pc[PC_WIDTH-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_hold_buffer.sv
// Single-entry parking register for a fetched instruction that arrived while
// decode was stalled and the F/D slot was still occupied.
module fetch_hold_buffer
  import fetch_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  clear_i,
  input  logic [PC_WIDTH-1:0]   pc_i,
  input  logic [INST_WIDTH-1:0] inst_i,
  output logic [PC_WIDTH-1:0]   pc_o,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic                  valid_o
);
  logic [PC_WIDTH-1:0]   pc_q;
  logic [INST_WIDTH-1:0] inst_q;
  logic                  valid_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q    <= '0;
      inst_q  <= '0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      pc_q    <= pc_i;
      inst_q  <= inst_i;
      valid_q <= 1'b1;
    end
  end

  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, keeps one imem request in flight and feeds the
// F/D register, honouring decode stalls and execute-stage redirects.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [PC_WIDTH-1:0] PC_STEP  = 32'd4
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  imemReqValid,
  input  logic                  imemReqReady,
  output logic [PC_WIDTH-1:0]   imemReqAddr,
  input  logic                  imemRespValid,
  input  logic [INST_WIDTH-1:0] imemRespData,
  input  logic                  redirectValid,
  input  logic [PC_WIDTH-1:0]   redirectPc,
  input  logic                  stall,
  output logic [PC_WIDTH-1:0]   pcOut,
  output logic [INST_WIDTH-1:0] instOut,
  output logic                  validOut
);
  fetch_state_t          state_q, state_d;
  logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0]   req_pc_q, req_pc_d;
  logic                  discard_q, discard_d;
  logic [PC_WIDTH-1:0]   pc_out_q, pc_out_d;
  logic [INST_WIDTH-1:0] inst_out_q, inst_out_d;
  logic                  valid_out_q, valid_out_d;

  logic                  hold_load, hold_clear, hold_valid;
  logic [PC_WIDTH-1:0]   hold_pc;
  logic [INST_WIDTH-1:0] hold_inst;
  logic                  handshake, slot_free;

  fetch_hold_buffer u_hold (
    .clock   (clock),
    .reset   (reset),
    .load_i  (hold_load),
    .clear_i (hold_clear),
    .pc_i    (req_pc_q),
    .inst_i  (imemRespData),
    .pc_o    (hold_pc),
    .inst_o  (hold_inst),
    .valid_o (hold_valid)
  );

  // Request valid is a pure function of state so it never combinationally
  // depends on the memory's ready.
  assign imemReqValid = (state_q == S_REQ) && reset;
  assign imemReqAddr  = fetch_pc_q;
  assign handshake    = imemReqValid && imemReqReady;
  assign slot_free    = !valid_out_q || !stall;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    discard_d   = discard_q;
    pc_out_d    = pc_out_q;
    inst_out_d  = inst_out_q;
    valid_out_d = valid_out_q && stall;
    hold_load   = 1'b0;
    hold_clear  = 1'b0;

    if (redirectValid) begin
      // Flush wins over stall; anything already in flight becomes stale.
      fetch_pc_d  = align_word(redirectPc);
      valid_out_d = 1'b0;
      hold_clear  = 1'b1;
      case (state_q)
        S_REQ: begin
          if (handshake) begin
            req_pc_d  = fetch_pc_q;
            state_d   = S_WAIT;
            discard_d = 1'b1;
          end
        end
        S_WAIT: begin
          if (imemRespValid) begin
            state_d   = S_REQ;
            discard_d = 1'b0;
          end else begin
            discard_d = 1'b1;
          end
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (handshake) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PC_STEP;
            state_d    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imemRespValid) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = S_REQ;
            end else if (slot_free) begin
              pc_out_d    = req_pc_q;
              inst_out_d  = imemRespData;
              valid_out_d = 1'b1;
              state_d     = S_REQ;
            end else begin
              hold_load = 1'b1;
              state_d   = S_HOLD;
            end
          end
        end
        default: begin
          if (!stall) begin
            pc_out_d    = hold_pc;
            inst_out_d  = hold_inst;
            valid_out_d = hold_valid;
            hold_clear  = 1'b1;
            state_d     = S_REQ;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_REQ;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= '0;
      discard_q   <= 1'b0;
      pc_out_q    <= '0;
      inst_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      discard_q   <= discard_d;
      pc_out_q    <= pc_out_d;
      inst_out_q  <= inst_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign pcOut    = pc_out_q;
  assign instOut  = inst_out_q;
  assign validOut = valid_out_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed cycle-by-cycle bench for instruction_fetch_unit with hand-computed
// expectations for every observed value.
module tb_instruction_fetch_unit;
  logic        clock = 1'b0;
  logic        reset;
  logic        imemReqValid;
  logic        imemReqReady;
  logic [31:0] imemReqAddr;
  logic        imemRespValid;
  logic [31:0] imemRespData;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        stall;
  logic [31:0] pcOut;
  logic [31:0] instOut;
  logic        validOut;

  int checks   = 0;
  int failures = 0;

  instruction_fetch_unit dut (
    .clock         (clock),
    .reset         (reset),
    .imemReqValid  (imemReqValid),
    .imemReqReady  (imemReqReady),
    .imemReqAddr   (imemReqAddr),
    .imemRespValid (imemRespValid),
    .imemRespData  (imemRespData),
    .redirectValid (redirectValid),
    .redirectPc    (redirectPc),
    .stall         (stall),
    .pcOut         (pcOut),
    .instOut       (instOut),
    .validOut      (validOut)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One sequential fetch from S_REQ: accept, 1-cycle response, presented next.
  task automatic fetch_one(input logic [31:0] pc, input logic [31:0] inst);
    imemReqReady = 1'b1;
    check_value("req_valid", {31'd0, imemReqValid}, 32'd1);
    check_value("req_addr", imemReqAddr, pc);
    tick();
    check_value("req_valid_wait", {31'd0, imemReqValid}, 32'd0);
    imemRespValid = 1'b1;
    imemRespData  = inst;
    tick();
    imemRespValid = 1'b0;
    check_value("valid_out", {31'd0, validOut}, 32'd1);
    check_value("pc_out", pcOut, pc);
    check_value("inst_out", instOut, inst);
    $display("fetch pc=%h inst=%h", pcOut, instOut);
  endtask

  initial begin
    reset = 1'b0; imemReqReady = 1'b0; imemRespValid = 1'b0; imemRespData = '0;
    redirectValid = 1'b0; redirectPc = '0; stall = 1'b0;
    tick(); tick();
    check_value("rst_valid_out", {31'd0, validOut}, 32'd0);
    check_value("rst_req_valid", {31'd0, imemReqValid}, 32'd0);
    check_value("rst_pc_out", pcOut, 32'd0);
    check_value("rst_inst_out", instOut, 32'd0);
    reset = 1'b1;
    #1;

    // Free run
    fetch_one(32'h0, 32'hA000_0000);
    fetch_one(32'h4, 32'hA000_0004);
    fetch_one(32'h8, 32'hA000_0008);
    check_value("addr_c", imemReqAddr, 32'hC);
    tick();  // accept 0xC

    // Mid-run reset with a response in flight
    reset = 1'b0; imemRespValid = 1'b1; imemRespData = 32'hBAD0_BAD0;
    tick();
    check_value("mid_rst_valid", {31'd0, validOut}, 32'd0);
    check_value("mid_rst_req_valid", {31'd0, imemReqValid}, 32'd0);
    reset = 1'b1; imemReqReady = 1'b0;
    #1;
    check_value("mid_rst_addr", imemReqAddr, 32'h0);
    tick();  // stray response ignored in S_REQ
    imemRespValid = 1'b0;
    check_value("stray_resp_valid", {31'd0, validOut}, 32'd0);
    check_value("stray_resp_addr", imemReqAddr, 32'h0);
    $display("reset mid-run addr=%h", imemReqAddr);

    // Stall while the slot is full -> hold buffer
    fetch_one(32'h0, 32'hB000_0000);
    stall = 1'b1;
    tick();  // accept 0x4, slot kept by stall
    check_value("stall_keep_valid", {31'd0, validOut}, 32'd1);
    imemRespValid = 1'b1; imemRespData = 32'hC000_0004;
    tick();
    imemRespValid = 1'b0;
    check_value("hold_no_req", {31'd0, imemReqValid}, 32'd0);
    check_value("hold_pc_out", pcOut, 32'h0);
    tick();
    check_value("hold_no_req2", {31'd0, imemReqValid}, 32'd0);
    check_value("hold_inst_out", instOut, 32'hB000_0000);
    stall = 1'b0;
    tick();
    check_value("release_pc", pcOut, 32'h4);
    check_value("release_inst", instOut, 32'hC000_0004);
    check_value("release_valid", {31'd0, validOut}, 32'd1);
    check_value("release_addr", imemReqAddr, 32'h8);
    $display("hold release pc=%h inst=%h", pcOut, instOut);

    // Redirect while waiting; the late response must be discarded
    tick();  // accept 0x8
    redirectValid = 1'b1; redirectPc = 32'h0000_0100;
    tick();
    redirectValid = 1'b0;
    check_value("redir_wait_req", {31'd0, imemReqValid}, 32'd0);
    check_value("redir_wait_valid", {31'd0, validOut}, 32'd0);
    imemRespValid = 1'b1; imemRespData = 32'hDEAD_BEEF;
    tick();
    imemRespValid = 1'b0;
    check_value("stale_valid", {31'd0, validOut}, 32'd0);
    check_value("stale_inst", instOut, 32'hC000_0004);
    fetch_one(32'h100, 32'hA000_0100);

    // Redirect coincident with a response, misaligned target
    tick();  // accept 0x104
    imemRespValid = 1'b1; imemRespData = 32'h1111_1111;
    redirectValid = 1'b1; redirectPc = 32'h0000_0103;
    tick();
    imemRespValid = 1'b0; redirectValid = 1'b0;
    check_value("redir_resp_valid", {31'd0, validOut}, 32'd0);
    check_value("redir_resp_addr", imemReqAddr, 32'h100);
    check_value("redir_resp_inst", instOut, 32'hA000_0100);
    $display("redirect+resp next addr=%h", imemReqAddr);

    // Memory back-pressure
    imemReqReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_value("bp_req_valid", {31'd0, imemReqValid}, 32'd1);
      check_value("bp_addr", imemReqAddr, 32'h100);
    end

    // PC wrap at the top of the address space
    redirectValid = 1'b1; redirectPc = 32'hFFFF_FFFC;
    tick();
    redirectValid = 1'b0;
    fetch_one(32'hFFFF_FFFC, 32'hE000_0001);
    check_value("wrap_addr", imemReqAddr, 32'h0);

    // Redirect flushes a stalled slot
    imemReqReady = 1'b0; stall = 1'b1;
    tick();
    check_value("stall_valid", {31'd0, validOut}, 32'd1);
    redirectValid = 1'b1; redirectPc = 32'h0000_0200;
    tick();
    redirectValid = 1'b0;
    check_value("flush_valid", {31'd0, validOut}, 32'd0);
    check_value("flush_pc_hold", pcOut, 32'hFFFF_FFFC);
    check_value("flush_addr", imemReqAddr, 32'h200);
    stall = 1'b0;
    fetch_one(32'h200, 32'hA000_0200);

    // Redirect concurrent with a handshake -> response discarded
    imemReqReady = 1'b1; redirectValid = 1'b1; redirectPc = 32'h0000_0300;
    tick();
    redirectValid = 1'b0;
    check_value("hs_redir_req", {31'd0, imemReqValid}, 32'd0);
    imemRespValid = 1'b1; imemRespData = 32'h2222_2222;
    tick();
    imemRespValid = 1'b0;
    check_value("hs_redir_valid", {31'd0, validOut}, 32'd0);
    check_value("hs_redir_addr", imemReqAddr, 32'h300);
    fetch_one(32'h300, 32'hA000_0300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
